// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
//   NOP_INSTR      : instruction presented when no valid word is at the queue head
//   fetch_entry_t  : one fetch-queue entry, the fetched word and the address it came from
//   next_word_addr : sequential successor of a word address (wraps modulo 2^32)
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} entries.
//   clk, rst_n : clock, synchronous active-low reset (empties the queue)
//   push       : write push_data at the tail (ignored when full without a pop, or on flush)
//   push_data  : entry to write
//   pop        : drop the head entry (ignored when empty or on flush)
//   flush      : discard every entry this cycle; beats push and pop
//   full       : DEPTH entries held
//   empty      : no entries held
//   count      : number of entries held
//   head       : oldest entry (contents undefined when empty)
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output logic [CW-1:0] count,
    output fetch_entry_t head
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic          do_push;
    logic          do_pop;

    // NOTE: every signal written here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        do_pop   = pop && (count_q != '0) && !flush;
        do_push  = push && !flush && ((count_q != CW'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; an entry is only
    // ever read after it has been written, and count gates visibility.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end.
//   clk, rst_n   : clock, synchronous active-low reset
//   imem_req     : read strobe to the instruction memory
//   imem_addr    : word-aligned read address
//   imem_rdata   : read data, returned the cycle after imem_req
//   instr        : queue-head instruction (NOP when nothing is valid)
//   pc           : address of instr (holds the last presented value when the queue is empty)
//   instr_valid  : queue head is valid
//   instr_ready  : decoder accepts the head this cycle
//   PCsrc        : redirect request for the current head, paired with pc_target
//   pc_target    : redirect address; the two low bits are ignored
// Every read carries the epoch it was issued in; a redirect toggles the epoch so a
// response belonging to the abandoned path can never reach the queue.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        PCsrc,
    input  logic [31:0] pc_target
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         inflight_q, inflight_d;
    logic         inflight_epoch_q, inflight_epoch_d;
    logic [31:0]  inflight_pc_q, inflight_pc_d;
    logic         epoch_q, epoch_d;
    logic [31:0]  last_pc_q, last_pc_d;

    logic         fifo_push;
    logic         fifo_pop;
    logic         fifo_flush;
    logic         fifo_full;
    logic         fifo_empty;
    logic [CW-1:0] fifo_count;
    fetch_entry_t fifo_head;
    fetch_entry_t resp_entry;

    logic         redirect;
    logic         resp_ok;
    logic         issue;
    logic [31:0]  redirect_addr;
    logic [CW:0]  occupancy;

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (resp_entry),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    always_comb begin
        redirect      = rst_n && PCsrc;
        redirect_addr = pc_target & 32'hFFFF_FFFC;

        fifo_pop   = rst_n && !fifo_empty && instr_ready;
        fifo_flush = redirect;

        // A response lands only if it belongs to the live path; a redirect in
        // the response cycle flushes the queue and wins over the push.
        resp_ok          = inflight_q && (inflight_epoch_q == epoch_q) && !redirect;
        fifo_push        = rst_n && resp_ok && (!fifo_full || fifo_pop);
        resp_entry.pc    = inflight_pc_q;
        resp_entry.instr = imem_rdata;

        // Entries held plus the one about to land, minus the one leaving now.
        // A redirect empties everything, so the target always has room.
        occupancy = (CW + 1)'(fifo_count) + (CW + 1)'(inflight_q) - (CW + 1)'(fifo_pop);
        issue     = rst_n && (redirect || (occupancy < DEPTH_C));

        imem_req  = issue;
        imem_addr = PCsrc ? redirect_addr : fetch_pc_q;

        fetch_pc_d = fetch_pc_q;
        if (issue) begin
            fetch_pc_d = next_word_addr(imem_addr);
        end else if (redirect) begin
            fetch_pc_d = redirect_addr;
        end

        epoch_d          = epoch_q ^ redirect;
        inflight_d       = issue;
        inflight_epoch_d = epoch_d;
        inflight_pc_d    = imem_addr;

        last_pc_d = fifo_empty ? last_pc_q : fifo_head.pc;

        instr_valid = rst_n && !fifo_empty;
        instr       = instr_valid ? fifo_head.instr : NOP_INSTR;
        if (!rst_n) begin
            pc = RESET_PC;
        end else if (!fifo_empty) begin
            pc = fifo_head.pc;
        end else begin
            pc = last_pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q       <= RESET_PC;
            inflight_q       <= 1'b0;
            inflight_epoch_q <= 1'b0;
            inflight_pc_q    <= RESET_PC;
            epoch_q          <= 1'b0;
            last_pc_q        <= RESET_PC;
        end else begin
            fetch_pc_q       <= fetch_pc_d;
            inflight_q       <= inflight_d;
            inflight_epoch_q <= inflight_epoch_d;
            inflight_pc_q    <= inflight_pc_d;
            epoch_q          <= epoch_d;
            last_pc_q        <= last_pc_d;
        end
    end

endmodule
